// File: rtl/debug_abstract_cmd_pkg.sv
// debug_abstract_cmd_pkg: abstract command field layout, cmdtype and cmderr codes
package debug_abstract_cmd_pkg;

  localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'd0;
  localparam logic [7:0] CMDTYPE_QUICK      = 8'd1;
  localparam logic [7:0] CMDTYPE_ACCESS_MEM = 8'd2;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_BUSY       = 3'd1;
  localparam logic [2:0] ERR_NOTSUP     = 3'd2;
  localparam logic [2:0] ERR_EXCEPTION  = 3'd3;
  localparam logic [2:0] ERR_HALTRESUME = 3'd4;

  typedef struct packed {
    logic [7:0]  cmdtype;
    logic        rsvd;
    logic [2:0]  size;
    logic        postincrement;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } ac_cmd_t;

endpackage

// File: rtl/debug_abstract_cmd.sv
// debug_abstract_cmd: validates DMI abstract commands and sequences transfer/postexec phases to the core
module debug_abstract_cmd
  import debug_abstract_cmd_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            command_we,
  input  logic [31:0]     command_wdata,
  input  logic            data0_we,
  input  logic            data1_we,
  input  logic [XLEN-1:0] data_wdata,
  input  logic [2:0]      cmderr_w1c,
  input  logic            hart_halted,
  input  logic            ac_done,
  input  logic            ac_exception,
  input  logic [XLEN-1:0] ac_rdata,
  output logic            abstract,
  output logic [31:0]     cmd,
  output logic [XLEN-1:0] data0,
  output logic [XLEN-1:0] data1,
  output logic            busy,
  output logic [2:0]      cmderr
);

  typedef enum logic [1:0] {IDLE, XFER, EXEC} state_e;

  state_e     state, state_d;
  ac_cmd_t    cmd_q, new_cmd, cmd_out;
  logic [2:0] val_err, err_new, err_kept;
  logic       idle, is_reg_n, is_quick_n, is_mem_n, is_reg, is_mem;
  logic       accept, reject, collide, xfer_ok, exec_ok, postinc;

  assign new_cmd    = ac_cmd_t'(command_wdata);
  assign is_reg_n   = new_cmd.cmdtype == CMDTYPE_ACCESS_REG;
  assign is_quick_n = new_cmd.cmdtype == CMDTYPE_QUICK;
  assign is_mem_n   = new_cmd.cmdtype == CMDTYPE_ACCESS_MEM;
  assign is_reg     = cmd_q.cmdtype == CMDTYPE_ACCESS_REG;
  assign is_mem     = cmd_q.cmdtype == CMDTYPE_ACCESS_MEM;
  assign idle       = state == IDLE;

  always_comb begin
    val_err = new_cmd.cmdtype > CMDTYPE_ACCESS_MEM                      ? ERR_NOTSUP
            : (is_reg_n && new_cmd.transfer && new_cmd.size != 3'd2)    ? ERR_NOTSUP
            : (is_mem_n && new_cmd.size > 3'd2)                         ? ERR_NOTSUP
            : ((is_reg_n || is_mem_n) && !hart_halted)                  ? ERR_HALTRESUME
            : (is_quick_n && hart_halted)                               ? ERR_HALTRESUME
            :                                                             ERR_NONE;
  end

  assign accept  = idle && command_we && cmderr == ERR_NONE && val_err == ERR_NONE;
  assign reject  = idle && command_we && cmderr == ERR_NONE && val_err != ERR_NONE;
  assign collide = !idle && (command_we || data0_we || data1_we);
  assign xfer_ok = state == XFER && ac_done && !ac_exception;
  assign exec_ok = state == EXEC && ac_done && !ac_exception;
  // register postincrement waits for postexec to finish; transfer=0 commands never increment
  assign postinc = cmd_q.postincrement &&
                   ((xfer_ok && !(is_reg && cmd_q.postexec)) || (exec_ok && is_reg && cmd_q.transfer));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = !accept ? IDLE
                    : (is_quick_n || (is_reg_n && !new_cmd.transfer)) ? EXEC : XFER;
      XFER: state_d = !ac_done ? XFER
                    : (!ac_exception && is_reg && cmd_q.postexec) ? EXEC : IDLE;
      EXEC: state_d = ac_done ? IDLE : EXEC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_out          = cmd_q;
    cmd_out.transfer = cmd_q.transfer && !(state == EXEC && is_reg);
    cmd              = cmd_out;
    abstract         = !idle;
    busy             = !idle;
  end

  // a new error beats a simultaneous clear, but never overwrites one that survives it
  assign err_new  = (!idle && ac_done && ac_exception) ? ERR_EXCEPTION
                  : reject                             ? val_err
                  : collide                            ? ERR_BUSY
                  :                                      ERR_NONE;
  assign err_kept = cmderr & ~cmderr_w1c;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cmderr <= ERR_NONE;
    else        cmderr <= (err_new != ERR_NONE && err_kept == ERR_NONE) ? err_new : err_kept;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_q <= '0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      if (accept) cmd_q <= new_cmd;
      else if (postinc && is_reg) cmd_q.regno <= cmd_q.regno + 16'd1;
      if (idle && data0_we) data0 <= data_wdata;
      else if (xfer_ok && !cmd_q.write) data0 <= ac_rdata;
      if (idle && data1_we) data1 <= data_wdata;
      else if (postinc && is_mem) data1 <= data1 + (XLEN'(1) << cmd_q.size);
    end

endmodule

// File: tb/tb_debug_abstract_cmd.sv
// tb_debug_abstract_cmd: directed vectors with hand-computed expectations for debug_abstract_cmd
module tb_debug_abstract_cmd;
  logic        clk = 0, rst_n = 0;
  logic        command_we = 0, data0_we = 0, data1_we = 0;
  logic [31:0] command_wdata = 0, data_wdata = 0, ac_rdata = 0;
  logic [2:0]  cmderr_w1c = 0;
  logic        hart_halted = 1, ac_done = 0, ac_exception = 0;
  logic        abstract, busy;
  logic [31:0] cmd, data0, data1;
  logic [2:0]  cmderr;
  int n_chk = 0, n_pass = 0;

  debug_abstract_cmd #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .command_we(command_we), .command_wdata(command_wdata),
    .data0_we(data0_we), .data1_we(data1_we), .data_wdata(data_wdata),
    .cmderr_w1c(cmderr_w1c), .hart_halted(hart_halted), .ac_done(ac_done),
    .ac_exception(ac_exception), .ac_rdata(ac_rdata), .abstract(abstract), .cmd(cmd),
    .data0(data0), .data1(data1), .busy(busy), .cmderr(cmderr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] c);
    command_we = 1; command_wdata = c;
    tick();
    command_we = 0;
  endtask

  task automatic done(input logic [31:0] rd, input logic exc);
    ac_done = 1; ac_rdata = rd; ac_exception = exc;
    tick();
    ac_done = 0; ac_exception = 0;
  endtask

  task automatic clear_err();
    cmderr_w1c = 3'h7;
    tick();
    cmderr_w1c = 0;
    check("w1c_clear", cmderr, 0);
  endtask

  initial begin
    #2;
    check("rst_abstract", abstract, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd", cmd, 0);
    check("rst_cmderr", cmderr, 0);
    tick();
    rst_n = 1;
    tick();

    issue(32'h0022_1001);
    check("rd_busy", busy, 1);
    check("rd_abstract", abstract, 1);
    check("rd_cmd", cmd, 32'h0022_1001);
    tick(); tick();
    check("rd_still_busy", busy, 1);
    done(32'hDEAD_BEEF, 0);
    check("rd_data0", data0, 32'hDEAD_BEEF);
    check("rd_busy_low", busy, 0);
    check("rd_cmderr", cmderr, 0);

    issue(32'h002E_1005);
    check("pe_xfer_cmd", cmd, 32'h002E_1005);
    tick();
    done(32'h1234_5678, 0);
    check("pe_exec_cmd", cmd, 32'h002C_1005);
    check("pe_exec_busy", busy, 1);
    check("pe_readback", data0, 32'h1234_5678);
    tick();
    done(32'h0, 0);
    check("pe_busy_low", busy, 0);
    check("pe_regno_inc", cmd, 32'h002E_1006);

    data1_we = 1; data_wdata = 32'hFFFF_FFFE;
    tick();
    data1_we = 0;
    check("mem_data1_wr", data1, 32'hFFFF_FFFE);
    issue(32'h0219_0000);
    check("mem_busy", busy, 1);
    done(32'hBAD0_BAD0, 0);
    check("mem_data1_wrap", data1, 32'h0);
    check("mem_data0_kept", data0, 32'h1234_5678);

    hart_halted = 0;
    issue(32'h0022_1000);
    check("run_haltresume", cmderr, 4);
    check("run_not_busy", busy, 0);
    clear_err();
    hart_halted = 1;
    issue(32'h0300_0000);
    check("bad_type", cmderr, 2);
    issue(32'h0022_1000);
    check("ignored_busy", busy, 0);
    check("ignored_err", cmderr, 2);
    clear_err();
    issue(32'h0100_0000);
    check("quick_halted", cmderr, 4);
    clear_err();
    issue(32'h0032_1000);
    check("bad_aarsize", cmderr, 2);
    clear_err();
    issue(32'h0230_0000);
    check("bad_aamsize", cmderr, 2);
    clear_err();

    data0_we = 1; data_wdata = 32'hA5A5_A5A5;
    tick();
    data0_we = 0;
    check("d0_wr", data0, 32'hA5A5_A5A5);
    issue(32'h0023_1000);
    data0_we = 1; data_wdata = 32'h1111_1111;
    tick();
    data0_we = 0;
    check("coll_err", cmderr, 1);
    check("coll_data0", data0, 32'hA5A5_A5A5);
    check("coll_busy", busy, 1);
    done(32'h7777_7777, 0);
    check("coll_done", busy, 0);
    check("coll_data0_after", data0, 32'hA5A5_A5A5);
    clear_err();

    issue(32'h002A_1002);
    done(32'h9999_9999, 1);
    check("exc_err", cmderr, 3);
    check("exc_data0", data0, 32'hA5A5_A5A5);
    check("exc_regno", cmd, 32'h002A_1002);
    check("exc_busy", busy, 0);
    clear_err();

    done(32'h5555_5555, 0);
    check("idle_done_data0", data0, 32'hA5A5_A5A5);
    check("idle_done_busy", busy, 0);

    issue(32'h0022_1003);
    rst_n = 0;
    #1;
    check("arst_abstract", abstract, 0);
    check("arst_busy", busy, 0);
    check("arst_data0", data0, 0);
    check("arst_cmd", cmd, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
